cpu_fetch_hq: RTL

- Second-generation moxie instruction fetch unit with a parametrised halfword-granular instruction queue.
- Fetches 32-bit words from instruction memory through a wait-state-tolerant strobe/ack handshake, aligns variable-length moxie instructions, and presents whole instructions (16-bit opcode plus optional 32-bit operand) with their PC to decode.
- Supports redirects to any halfword-aligned branch target.
- Sits between the instruction memory port and cpu_decode.

---
 rtl/cpu_fetch_pkg.sv | 28 ++
 rtl/cpu_hw_queue.sv | 76 +++++++
 rtl/cpu_fetch_hq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and instruction-length decode for the moxie fetch unit.
package cpu_fetch_pkg;

    typedef logic [15:0] halfword_t;

    localparam int unsigned INSN_SHORT_HW = 1;
    localparam int unsigned INSN_LONG_HW  = 3;

    // Form-1 opcodes carrying a 32-bit immediate/address word after the opcode.
    function automatic logic is_long(input halfword_t op);
        logic r;
        casez (op)
            16'h01??,                               // ldi.l
            16'h03??,                               // jsra
            16'h08??, 16'h09??,                     // lda.l, sta.l
            16'h0c??, 16'h0d??,                     // ldo.l, sto.l
            16'h1a??,                               // jmpa
            16'h1b??, 16'h1d??, 16'h1f??,           // ldi.b, lda.b, sta.b
            16'h20??, 16'h22??, 16'h24??,           // ldi.s, lda.s, sta.s
            16'h36??, 16'h37??, 16'h38??, 16'h39??: // ldo.b, sto.b, ldo.s, sto.s
                r = 1'b1;
            default:
                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_hw_queue.sv
// Circular halfword queue: push 1/2, pop 1/3, three-entry peek at the head, flush.
module cpu_hw_queue
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned QDEPTH_LOG2 = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 push_two_i,
    input  halfword_t            push_hw0_i,
    input  halfword_t            push_hw1_i,
    input  logic                 pop_i,
    input  logic                 pop_three_i,
    output halfword_t            peek0_o,
    output halfword_t            peek1_o,
    output halfword_t            peek2_o,
    output logic [QDEPTH_LOG2:0] level_o
);

    localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;
    localparam int unsigned PW    = QDEPTH_LOG2;
    localparam int unsigned LW    = QDEPTH_LOG2 + 1;

    halfword_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]     level_q, level_d;
    logic [PW-1:0]     push_n, pop_n;
    logic [PW-1:0]     tail_p1, head_p1, head_p2;

    assign tail_p1 = tail_q + PW'(1);
    assign head_p1 = head_q + PW'(1);
    assign head_p2 = head_q + PW'(2);

    always_comb begin
        push_n  = push_i ? (push_two_i ? PW'(2) : PW'(1)) : '0;
        pop_n   = pop_i ? (pop_three_i ? PW'(3) : PW'(1)) : '0;
        head_d  = head_q + pop_n;
        tail_d  = tail_q + push_n;
        level_d = level_q + LW'(push_n) - LW'(pop_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: nothing is visible until level covers it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_hw0_i;
            if (push_two_i) begin
                mem_q[tail_p1] <= push_hw1_i;
            end
        end
    end

    assign peek0_o = mem_q[head_q];
    assign peek1_o = mem_q[head_p1];
    assign peek2_o = mem_q[head_p2];
    assign level_o = level_q;

endmodule

// File: rtl/cpu_fetch_hq.sv
// Moxie fetch unit: word fetch over strobe/ack, halfword queue alignment, branch redirect.
module cpu_fetch_hq
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
    parameter int unsigned QDEPTH_LOG2  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [31:0]          imem_address_o,
    output logic                 imem_stb_o,
    input  logic                 imem_ack_i,
    input  logic [31:0]          imem_data_i,
    input  logic                 branch_flag_i,
    input  logic [31:0]          branch_target_i,
    input  logic                 stall_i,
    output logic [15:0]          opcode,
    output logic [31:0]          operand,
    output logic                 valid,
    output logic [31:0]          PC_o,
    output logic [QDEPTH_LOG2:0] qlevel_o
);

    localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;
    localparam int unsigned LW    = QDEPTH_LOG2 + 1;

    if (QDEPTH_LOG2 < 2 || QDEPTH_LOG2 > 6) begin : g_bad_depth
        $error("cpu_fetch_hq: QDEPTH_LOG2 must lie in 2..6");
    end

    logic [31:0]   fetch_pc_q, fetch_pc_d, pc_q, pc_d;
    logic          skip_low_q, skip_low_d, discard_q, discard_d, stb_q, stb_d;
    halfword_t     peek0, peek1, peek2;
    logic [LW-1:0] level, push_n, pop_n, level_next;
    logic          head_long, pop, push, issue_ok;

    assign head_long = is_long(peek0);
    assign valid     = head_long ? (level >= LW'(INSN_LONG_HW)) : (level >= LW'(INSN_SHORT_HW));
    assign opcode    = valid ? peek0 : '0;
    assign operand   = (valid && head_long) ? {peek1, peek2} : '0;
    assign pop       = valid && !stall_i && !branch_flag_i;
    assign push      = stb_q && imem_ack_i && !branch_flag_i;

    // Issue decision looks at the level after this cycle's push and pop.
    assign push_n     = push ? (skip_low_q ? LW'(INSN_SHORT_HW) : LW'(2)) : '0;
    assign pop_n      = pop ? (head_long ? LW'(INSN_LONG_HW) : LW'(INSN_SHORT_HW)) : '0;
    assign level_next = level + push_n - pop_n;
    assign issue_ok   = level_next <= LW'(DEPTH - 2);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        skip_low_d = skip_low_q;
        discard_d  = discard_q;
        stb_d      = stb_q;
        if (pop) begin
            pc_d = pc_q + (head_long ? 32'(2 * INSN_LONG_HW) : 32'(2 * INSN_SHORT_HW));
        end
        if (branch_flag_i) begin
            pc_d       = branch_target_i & ~32'd1;
            fetch_pc_d = branch_target_i & ~32'd3;
            skip_low_d = branch_target_i[1];
            // A request still in flight must have its ack swallowed before refetching.
            if ((stb_q || discard_q) && !imem_ack_i) begin
                discard_d = 1'b1;
                stb_d     = 1'b0;
            end else begin
                discard_d = 1'b0;
                stb_d     = 1'b1;
            end
        end else if (discard_q) begin
            if (imem_ack_i) begin
                discard_d = 1'b0;
                stb_d     = issue_ok;
            end
        end else if (stb_q) begin
            if (imem_ack_i) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                skip_low_d = 1'b0;
                stb_d      = issue_ok;
            end
        end else begin
            stb_d = issue_ok;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= BOOT_ADDRESS;
            pc_q       <= BOOT_ADDRESS;
            skip_low_q <= 1'b0;
            discard_q  <= 1'b0;
            stb_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            skip_low_q <= skip_low_d;
            discard_q  <= discard_d;
            stb_q      <= stb_d;
        end
    end

    cpu_hw_queue #(
        .QDEPTH_LOG2(QDEPTH_LOG2)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (branch_flag_i),
        .push_i      (push),
        .push_two_i  (!skip_low_q),
        .push_hw0_i  (skip_low_q ? imem_data_i[15:0] : imem_data_i[31:16]),
        .push_hw1_i  (imem_data_i[15:0]),
        .pop_i       (pop),
        .pop_three_i (head_long),
        .peek0_o     (peek0),
        .peek1_o     (peek1),
        .peek2_o     (peek2),
        .level_o     (level)
    );

    assign imem_address_o = fetch_pc_q;
    assign imem_stb_o     = stb_q;
    assign PC_o           = pc_q;
    assign qlevel_o       = level;

endmodule
